mem_arbiter: RTL and testbench

MEM_ARBITER -- requirements
Module: mem_arbiter

---
 rtl/mem_arbiter.sv | 185 ++++++++++++++++++
 tb/tb_mem_arbiter.sv | 253 +++++++++++++++++++++++++
 2 files changed

// File: rtl/mem_arbiter.sv
// Byte-wide RAM port arbiter shared between instruction fetch and load/store.
// Optional fetch buffer enabled with `define INST_BUF_EN.
`timescale 1ns/1ps
module mem_arbiter (
  input  logic        clk,
  input  logic        rst,
  input  logic        inst_req,
  input  logic [31:0] inst_addr,
  output logic [31:0] inst_o,
  output logic [31:0] inst_pc,
  output logic        inst_done,
  input  logic        data_req,
  input  logic        data_we,
  input  logic [31:0] data_addr,
  input  logic [1:0]  data_len,
  input  logic [31:0] data_wdata,
  output logic [31:0] data_rdata,
  output logic        data_done,
  input  logic [7:0]  mem_din,
  output logic [7:0]  mem_dout,
  output logic [31:0] mem_a,
  output logic        mem_wr
);

  localparam logic [1:0] IDLE   = 2'd0;
  localparam logic [1:0] IREAD  = 2'd1;
  localparam logic [1:0] DREAD  = 2'd2;
  localparam logic [1:0] DWRITE = 2'd3;

  logic [1:0]  state_q, state_d;
  logic [31:0] base_q, base_d;
  logic [2:0]  len_q, len_d;
  logic [2:0]  cnt_q, cnt_d;
  logic [31:0] wdata_q, wdata_d;
  logic [31:0] buf_q, buf_d;
  logic [31:0] inst_q, inst_d;
  logic [31:0] pc_q, pc_d;
  logic        inst_done_q, inst_done_d;
  logic [31:0] rdata_q, rdata_d;
  logic        data_done_q, data_done_d;
  logic        instHit;
  logic        storeHitsInst;
  logic [5:0]  laneShift;
  logic [7:0]  wrByte;

  function automatic logic [2:0] lenBytes(input logic [1:0] code);
    case (code)
      2'd0:    lenBytes = 3'd1;
      2'd1:    lenBytes = 3'd2;
      default: lenBytes = 3'd4;
    endcase
  endfunction

`ifdef INST_BUF_EN
  logic [31:0] storeMinusPc;
  logic [31:0] pcMinusStore;

  // A valid buffered instruction at the requested address satisfies the fetch.
  assign instHit       = inst_done_q && (inst_addr == pc_q);
  // Modular distances so ranges crossing 0xFFFFFFFF are handled.
  assign storeMinusPc  = base_q - pc_q;
  assign pcMinusStore  = pc_q - base_q;
  assign storeHitsInst = (storeMinusPc < 32'd4) || (pcMinusStore < {29'd0, len_q});
`else
  assign instHit       = 1'b0;
  assign storeHitsInst = 1'b0;
`endif

  // mem_din carries the byte addressed one cycle earlier, i.e. lane cnt_q-1.
  assign laneShift = {cnt_q - 3'd1, 3'b000};

  always_comb begin
    state_d     = state_q;
    base_d      = base_q;
    len_d       = len_q;
    cnt_d       = cnt_q;
    wdata_d     = wdata_q;
    buf_d       = buf_q;
    inst_d      = inst_q;
    pc_d        = pc_q;
    inst_done_d = inst_done_q;
    rdata_d     = rdata_q;
    data_done_d = 1'b0;
    case (state_q)
      IDLE: begin
        if (data_req) begin
          state_d = data_we ? DWRITE : DREAD;
          base_d  = data_addr;
          len_d   = lenBytes(data_len);
          wdata_d = data_wdata;
          cnt_d   = 3'd0;
          buf_d   = 32'd0;
        end else if (inst_req && !instHit) begin
          state_d     = IREAD;
          base_d      = inst_addr;
          len_d       = 3'd4;
          cnt_d       = 3'd0;
          buf_d       = 32'd0;
          inst_done_d = 1'b0;
        end
      end
      IREAD, DREAD: begin
        if (cnt_q != 3'd0) begin
          buf_d = buf_q | ({24'd0, mem_din} << laneShift);
        end
        if (cnt_q == len_q) begin
          state_d = IDLE;
          if (state_q == IREAD) begin
            inst_d      = buf_d;
            pc_d        = base_q;
            inst_done_d = 1'b1;
          end else begin
            rdata_d     = buf_d;
            data_done_d = 1'b1;
          end
        end else begin
          cnt_d = cnt_q + 3'd1;
        end
      end
      DWRITE: begin
        if (cnt_q == len_q - 3'd1) begin
          state_d     = IDLE;
          data_done_d = 1'b1;
          if (storeHitsInst) begin
            inst_done_d = 1'b0;
          end
        end else begin
          cnt_d = cnt_q + 3'd1;
        end
      end
      default: state_d = IDLE;
    endcase
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state_q     <= IDLE;
      base_q      <= 32'd0;
      len_q       <= 3'd0;
      cnt_q       <= 3'd0;
      wdata_q     <= 32'd0;
      buf_q       <= 32'd0;
      inst_q      <= 32'd0;
      pc_q        <= 32'd0;
      inst_done_q <= 1'b0;
      rdata_q     <= 32'd0;
      data_done_q <= 1'b0;
    end else begin
      state_q     <= state_d;
      base_q      <= base_d;
      len_q       <= len_d;
      cnt_q       <= cnt_d;
      wdata_q     <= wdata_d;
      buf_q       <= buf_d;
      inst_q      <= inst_d;
      pc_q        <= pc_d;
      inst_done_q <= inst_done_d;
      rdata_q     <= rdata_d;
      data_done_q <= data_done_d;
    end
  end

  always_comb begin
    wrByte = 8'h00;
    if (state_q == DWRITE) begin
      case (cnt_q[1:0])
        2'd0:    wrByte = wdata_q[7:0];
        2'd1:    wrByte = wdata_q[15:8];
        2'd2:    wrByte = wdata_q[23:16];
        default: wrByte = wdata_q[31:24];
      endcase
    end
  end

  // The extra read cycle that only collects the last byte drives no address.
  assign mem_a      = (state_q != IDLE && cnt_q < len_q) ? base_q + {29'd0, cnt_q} : 32'd0;
  assign mem_wr     = (state_q == DWRITE);
  assign mem_dout   = wrByte;
  assign inst_o     = inst_q;
  assign inst_pc    = pc_q;
  assign inst_done  = inst_done_q;
  assign data_rdata = rdata_q;
  assign data_done  = data_done_q;

endmodule

// File: tb/tb_mem_arbiter.sv
// Self-checking bench for mem_arbiter: directed vector table, multi-cycle corner
// sequences and randomized traffic against a byte-array memory model.
`timescale 1ns/1ps
module tb_mem_arbiter;

   logic        clk;
   logic        rst;
   logic        inst_req;
   logic [31:0] inst_addr;
   logic [31:0] inst_o;
   logic [31:0] inst_pc;
   logic        inst_done;
   logic        data_req;
   logic        data_we;
   logic [31:0] data_addr;
   logic [1:0]  data_len;
   logic [31:0] data_wdata;
   logic [31:0] data_rdata;
   logic        data_done;
   logic [7:0]  mem_din;
   logic [7:0]  mem_dout;
   logic [31:0] mem_a;
   logic        mem_wr;

   logic [7:0]  ram [0:4095];
   logic [7:0]  refMem [0:4095];
   int          checks = 0;
   int          failures = 0;

   typedef struct {
      int          kind;
      logic [31:0] addr;
      logic [1:0]  len;
      logic [31:0] wdata;
      logic [31:0] expData;
   } vec_t;

   vec_t vecs [13];

   mem_arbiter dut (
      .clk(clk), .rst(rst),
      .inst_req(inst_req), .inst_addr(inst_addr), .inst_o(inst_o),
      .inst_pc(inst_pc), .inst_done(inst_done),
      .data_req(data_req), .data_we(data_we), .data_addr(data_addr),
      .data_len(data_len), .data_wdata(data_wdata), .data_rdata(data_rdata),
      .data_done(data_done),
      .mem_din(mem_din), .mem_dout(mem_dout), .mem_a(mem_a), .mem_wr(mem_wr)
   );

   initial clk = 1'b0;
   always #5 clk = ~clk;

   // RAM device: one-cycle read latency, 4 KiB aliased so wrapping addresses work.
   always @(posedge clk) begin
      if (mem_wr) ram[mem_a[11:0]] <= mem_dout;
      mem_din <= ram[mem_a[11:0]];
   end

   initial begin
      #2000000;
      $display("[TB] FAIL watchdog actual=timeout expected=finish");
      $fatal(1, "[TB] watchdog expired");
   end

   task automatic checkOutput(input string name, input logic [31:0] act, input logic [31:0] exp);
      checks++;
      if (act !== exp) begin
         failures++;
         $display("[TB] FAIL %s actual=0x%08h expected=0x%08h", name, act, exp);
      end
   endtask

   function automatic int lenBytes(input logic [1:0] code);
      return (code == 2'd0) ? 1 : (code == 2'd1) ? 2 : 4;
   endfunction

   function automatic logic [31:0] modelRead(input logic [31:0] addr, input int n);
      logic [31:0] v = 32'd0;
      for (int i = 0; i < n; i++) begin
         logic [31:0] a = addr + i;
         v = v | (32'(refMem[a[11:0]]) << (8 * i));
      end
      return v;
   endfunction

   function automatic void modelWrite(input logic [31:0] addr, input int n, input logic [31:0] wd);
      for (int i = 0; i < n; i++) begin
         logic [31:0] a = addr + i;
         refMem[a[11:0]] = 8'((wd >> (8 * i)) & 32'hFF);
      end
   endfunction

   // kind: 0 = load, 1 = store, 2 = fetch. Checks timing, bus activity and result.
   task automatic applyStimulus(input int kind, input logic [31:0] addr, input logic [1:0] len,
                                input logic [31:0] wdata, output logic [31:0] result);
      int n = (kind == 2) ? 4 : lenBytes(len);
      int expLat = (kind == 1) ? n : n + 1;
      int lat = -1;
      int wrCnt = 0;
      logic [31:0] expVal = modelRead(addr, n);
      logic doneNow;
      @(negedge clk);
      if (kind == 2) begin
         inst_req = 1'b1; inst_addr = addr;
      end else begin
         data_req = 1'b1; data_we = (kind == 1); data_addr = addr;
         data_len = len; data_wdata = wdata;
      end
      @(posedge clk); #1;
      inst_req = 1'b0; data_req = 1'b0;
      data_addr = $urandom; data_len = 2'($urandom); data_wdata = $urandom;
      if (kind == 2) checkOutput("inst_done_drop", {31'd0, inst_done}, 32'd0);
      for (int k = 0; k < 12; k++) begin
         if (k > 0) begin
            @(posedge clk); #1;
         end
         if (k == 2) inst_addr = addr + 32'h100;
         doneNow = (kind == 2) ? inst_done : data_done;
         if (doneNow) begin
            lat = k;
            break;
         end
         if (k < n) checkOutput("mem_a", mem_a, addr + k);
         if (mem_wr) begin
            checkOutput("mem_dout", {24'd0, mem_dout}, (wdata >> (8 * wrCnt)) & 32'hFF);
            wrCnt++;
         end
      end
      checkOutput("latency", lat, expLat);
      checkOutput("mem_wr_cycles", wrCnt, (kind == 1) ? n : 0);
      checkOutput("idle_bus", {mem_a[31:9], mem_wr, mem_dout}, 32'd0);
      if (kind == 0) checkOutput("data_rdata", data_rdata, expVal);
      if (kind == 2) begin
         checkOutput("inst_o", inst_o, expVal);
         checkOutput("inst_pc", inst_pc, addr);
      end
      result = (kind == 2) ? inst_o : data_rdata;
      @(posedge clk); #1;
      if (kind == 2) checkOutput("inst_done_hold", {31'd0, inst_done}, 32'd1);
      else           checkOutput("done_pulse", {31'd0, data_done}, 32'd0);
      if (kind == 1) modelWrite(addr, n, wdata);
   endtask

   task automatic waitDone(input bit isInst, output int lat);
      lat = -1;
      for (int k = 1; k < 12; k++) begin
         @(posedge clk); #1;
         if ((isInst && inst_done) || (!isInst && data_done)) begin
            lat = k;
            break;
         end
      end
   endtask

   initial begin
      logic [31:0] res;
      logic [31:0] expA;
      int lat;
      int seen;
      for (int i = 0; i < 4096; i++) begin
         logic [7:0] b = 8'($urandom);
         ram[i] = b; refMem[i] = b;
      end
      ram[12'h100] = 8'h13; ram[12'h101] = 8'h05; ram[12'h102] = 8'h10; ram[12'h103] = 8'h00;
      modelWrite(32'h100, 4, 32'h00100513);

      vecs[0]  = '{2, 32'h0000_0100, 2'd2, 32'h0, 32'h0010_0513};
      vecs[1]  = '{1, 32'h0000_0040, 2'd1, 32'h0000_ABCD, 32'h0};
      vecs[2]  = '{0, 32'h0000_0041, 2'd0, 32'h0, 32'h0000_00AB};
      vecs[3]  = '{0, 32'h0000_0040, 2'd1, 32'h0, 32'h0000_ABCD};
      vecs[4]  = '{1, 32'h0000_0080, 2'd2, 32'h1122_3344, 32'h0};
      vecs[5]  = '{0, 32'h0000_0080, 2'd3, 32'h0, 32'h1122_3344};
      vecs[6]  = '{0, 32'h0000_0083, 2'd0, 32'h0, 32'h0000_0011};
      vecs[7]  = '{1, 32'h0000_0042, 2'd0, 32'h0000_005A, 32'h0};
      vecs[8]  = '{0, 32'h0000_0041, 2'd1, 32'h0, 32'h0000_5AAB};
      vecs[9]  = '{1, 32'hFFFF_FFFE, 2'd2, 32'hCAFE_F00D, 32'h0};
      vecs[10] = '{0, 32'hFFFF_FFFE, 2'd2, 32'h0, 32'hCAFE_F00D};
      vecs[11] = '{0, 32'hFFFF_FFFF, 2'd0, 32'h0, 32'h0000_00F0};
      vecs[12] = '{2, 32'h0000_0080, 2'd2, 32'h0, 32'h1122_3344};

      rst = 1'b1; inst_req = 1'b0; inst_addr = 32'd0; data_req = 1'b0; data_we = 1'b0;
      data_addr = 32'd0; data_len = 2'd0; data_wdata = 32'd0;
      repeat (3) @(posedge clk);
      #1;
      checkOutput("rst_inst_o", inst_o, 32'd0);
      checkOutput("rst_inst_pc", inst_pc, 32'd0);
      checkOutput("rst_flags", {28'd0, inst_done, data_done, mem_wr, 1'b0}, 32'd0);
      checkOutput("rst_data_rdata", data_rdata, 32'd0);
      checkOutput("rst_mem_a", mem_a, 32'd0);
      checkOutput("rst_mem_dout", {24'd0, mem_dout}, 32'd0);
      rst = 1'b0;

      $display("[TB] directed vector table");
      for (int v = 0; v < 13; v++) begin
         applyStimulus(vecs[v].kind, vecs[v].addr, vecs[v].len, vecs[v].wdata, res);
         if (vecs[v].kind != 1) checkOutput($sformatf("table_%0d", v), res, vecs[v].expData);
      end

      $display("[TB] contention: load and fetch in the same cycle");
      expA = modelRead(32'h200, 4);
      @(negedge clk);
      inst_req = 1'b1; inst_addr = 32'h104;
      data_req = 1'b1; data_we = 1'b0; data_addr = 32'h200; data_len = 2'd2;
      @(posedge clk); #1;
      data_req = 1'b0;
      checkOutput("cont_dread_first", mem_a, 32'h200);
      waitDone(1'b0, lat);
      checkOutput("cont_dlat", lat, 5);
      checkOutput("cont_rdata", data_rdata, expA);
      checkOutput("cont_inst_held", {31'd0, inst_done}, 32'd1);
      @(posedge clk); #1;
      inst_req = 1'b0;
      checkOutput("cont_iread_grant", {31'd0, inst_done}, 32'd0);
      checkOutput("cont_iread_addr", mem_a, 32'h104);
      waitDone(1'b1, lat);
      checkOutput("cont_ilat", lat, 5);
      checkOutput("cont_inst_o", inst_o, modelRead(32'h104, 4));
      checkOutput("cont_inst_pc", inst_pc, 32'h104);

      $display("[TB] reset in the middle of a word store");
      @(negedge clk);
      data_req = 1'b1; data_we = 1'b1; data_addr = 32'h300; data_len = 2'd2; data_wdata = 32'hDEAD_BEEF;
      @(posedge clk); #1;
      data_req = 1'b0;
      @(posedge clk); #1;
      checkOutput("rst_mid_wr_before", {31'd0, mem_wr}, 32'd1);
      rst = 1'b1;
      @(posedge clk); #1;
      rst = 1'b0;
      checkOutput("rst_mid_wr_after", {31'd0, mem_wr}, 32'd0);
      checkOutput("rst_mid_mem_a", mem_a, 32'd0);
      seen = 0;
      for (int k = 0; k < 6; k++) begin
         if (data_done) seen++;
         @(posedge clk); #1;
      end
      checkOutput("rst_mid_no_done", seen, 0);
      modelWrite(32'h300, 2, 32'h0000_BEEF);
      applyStimulus(0, 32'h300, 2'd1, 32'h0, res);

      $display("[TB] randomized traffic");
      for (int t = 0; t < 40; t++) begin
         int kind = $urandom_range(0, 2);
         logic [31:0] addr = ($urandom_range(0, 7) == 0) ? 32'hFFFF_FFFC + $urandom_range(0, 3)
                                                          : 32'h400 + $urandom_range(0, 255);
         applyStimulus(kind, addr, 2'($urandom), $urandom, res);
      end

      $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
      $finish;
   end

endmodule
